// File: rtl/dx_operand_stage.sv
// D/X pipeline register feeding the ALU: latches the decoded insn, resolves both
// operands through an X > M > W > regfile bypass, and raises load-use / hold stalls.
module dx_operand_stage #(
    parameter int REG_SIZE      = 8,
    parameter int INSN_OPC_SIZE = 4,
    parameter int REG_ADDR_SIZE = 4,
    parameter int CNT_SIZE      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     D_valid,
    input  logic [INSN_OPC_SIZE-1:0] D_insn_opc,
    input  logic [REG_ADDR_SIZE-1:0] D_src_0_addr,
    input  logic [REG_ADDR_SIZE-1:0] D_src_1_addr,
    input  logic                     D_src_0_used,
    input  logic                     D_src_1_used,
    input  logic [REG_SIZE-1:0]      D_src_0_rf,
    input  logic [REG_SIZE-1:0]      D_src_1_rf,
    input  logic [REG_ADDR_SIZE-1:0] D_dst_addr,
    input  logic                     D_wb_en,
    input  logic                     D_is_ld,
    input  logic [REG_SIZE-1:0]      X_result_ALU,
    input  logic                     XM_valid,
    input  logic                     XM_wb_en,
    input  logic [REG_ADDR_SIZE-1:0] XM_dst_addr,
    input  logic [REG_SIZE-1:0]      XM_result,
    input  logic                     MW_valid,
    input  logic                     MW_wb_en,
    input  logic [REG_ADDR_SIZE-1:0] MW_dst_addr,
    input  logic [REG_SIZE-1:0]      MW_result,
    input  logic                     X_flush,
    input  logic                     X_hold,
    output logic                     DX_valid,
    output logic [INSN_OPC_SIZE-1:0] DX_insn_opc,
    output logic [REG_SIZE-1:0]      src_0_data_ALU,
    output logic [REG_SIZE-1:0]      src_1_data_ALU,
    output logic [REG_ADDR_SIZE-1:0] DX_dst_addr,
    output logic                     DX_wb_en,
    output logic                     DX_is_ld,
    output logic                     D_stall,
    output logic [CNT_SIZE-1:0]      stall_cnt
);

    logic [1:0][REG_ADDR_SIZE-1:0] src_addr;
    logic [1:0][REG_SIZE-1:0]      src_rf;
    logic [1:0][REG_SIZE-1:0]      src_fwd;
    logic                          x_fwd_ok;
    logic                          load_use;

    assign src_addr = {D_src_1_addr, D_src_0_addr};
    assign src_rf   = {D_src_1_rf, D_src_0_rf};

    // A load in DX has no result yet, so it must not bypass from the ALU output.
    assign x_fwd_ok = DX_valid & DX_wb_en & ~DX_is_ld;

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        always_comb begin
            src_fwd[i] = src_rf[i];
            if (x_fwd_ok && DX_dst_addr == src_addr[i])
                src_fwd[i] = X_result_ALU;
            else if (XM_valid && XM_wb_en && XM_dst_addr == src_addr[i])
                src_fwd[i] = XM_result;
            else if (MW_valid && MW_wb_en && MW_dst_addr == src_addr[i])
                src_fwd[i] = MW_result;
        end
    end

    assign load_use = D_valid & DX_valid & DX_is_ld & DX_wb_en &
                      ((D_src_0_used & (DX_dst_addr == D_src_0_addr)) |
                       (D_src_1_used & (DX_dst_addr == D_src_1_addr)));

    assign D_stall = ~reset & ~X_flush & (X_hold | load_use);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DX_valid       <= 1'b0;
            DX_insn_opc    <= '0;
            src_0_data_ALU <= '0;
            src_1_data_ALU <= '0;
            DX_dst_addr    <= '0;
            DX_wb_en       <= 1'b0;
            DX_is_ld       <= 1'b0;
        end else if (X_flush) begin
            DX_valid <= 1'b0;
        end else if (X_hold) begin
            DX_valid <= DX_valid;
        end else if (load_use) begin
            DX_valid <= 1'b0;
        end else begin
            DX_valid <= D_valid;
            // Idle-to-idle cycles leave the payload untouched.
            if (D_valid || DX_valid) begin
                DX_insn_opc    <= D_insn_opc;
                src_0_data_ALU <= src_fwd[0];
                src_1_data_ALU <= src_fwd[1];
                DX_dst_addr    <= D_dst_addr;
                DX_wb_en       <= D_wb_en;
                DX_is_ld       <= D_is_ld;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (D_stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_dx_operand_stage.sv
// Randomized + directed bench for dx_operand_stage against a producer-list reference model.
module tb_dx_operand_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_valid, D_src_0_used, D_src_1_used, D_wb_en, D_is_ld;
    logic [3:0] D_insn_opc, D_src_0_addr, D_src_1_addr, D_dst_addr;
    logic [7:0] D_src_0_rf, D_src_1_rf, X_result_ALU, XM_result, MW_result;
    logic       XM_valid, XM_wb_en, MW_valid, MW_wb_en, X_flush, X_hold;
    logic [3:0] XM_dst_addr, MW_dst_addr;
    logic       DX_valid, DX_wb_en, DX_is_ld, D_stall;
    logic [3:0] DX_insn_opc, DX_dst_addr;
    logic [7:0] src_0_data_ALU, src_1_data_ALU;
    logic [15:0] stall_cnt;

    dx_operand_stage dut (
        .clk(clk), .reset(reset),
        .D_valid(D_valid), .D_insn_opc(D_insn_opc),
        .D_src_0_addr(D_src_0_addr), .D_src_1_addr(D_src_1_addr),
        .D_src_0_used(D_src_0_used), .D_src_1_used(D_src_1_used),
        .D_src_0_rf(D_src_0_rf), .D_src_1_rf(D_src_1_rf),
        .D_dst_addr(D_dst_addr), .D_wb_en(D_wb_en), .D_is_ld(D_is_ld),
        .X_result_ALU(X_result_ALU),
        .XM_valid(XM_valid), .XM_wb_en(XM_wb_en), .XM_dst_addr(XM_dst_addr), .XM_result(XM_result),
        .MW_valid(MW_valid), .MW_wb_en(MW_wb_en), .MW_dst_addr(MW_dst_addr), .MW_result(MW_result),
        .X_flush(X_flush), .X_hold(X_hold),
        .DX_valid(DX_valid), .DX_insn_opc(DX_insn_opc),
        .src_0_data_ALU(src_0_data_ALU), .src_1_data_ALU(src_1_data_ALU),
        .DX_dst_addr(DX_dst_addr), .DX_wb_en(DX_wb_en), .DX_is_ld(DX_is_ld),
        .D_stall(D_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'h1, SUB = 4'h2, LD = 4'h3;

    int n_chk = 0;
    int n_err = 0;

    // reference model: what the DX stage should hold
    logic       m_valid, m_wb, m_ld;
    logic [3:0] m_opc, m_dst;
    logic [7:0] m_s0, m_s1;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // youngest in-flight producer of a register wins, else the regfile value
    function automatic logic [7:0] resolve(input logic [3:0] a, input logic [7:0] rf);
        logic       ok[3];
        logic [3:0] d[3];
        logic [7:0] v[3];
        ok[0] = m_valid && m_wb && !m_ld; d[0] = m_dst;       v[0] = X_result_ALU;
        ok[1] = XM_valid && XM_wb_en;     d[1] = XM_dst_addr; v[1] = XM_result;
        ok[2] = MW_valid && MW_wb_en;     d[2] = MW_dst_addr; v[2] = MW_result;
        for (int i = 0; i < 3; i++)
            if (ok[i] && d[i] == a) return v[i];
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_ld = 0; m_opc = 0; m_dst = 0;
        m_s0 = 0; m_s1 = 0; m_cnt = 0;
    endtask

    task automatic idle();
        D_valid = 0; D_insn_opc = 0; D_src_0_addr = 0; D_src_1_addr = 0;
        D_src_0_used = 0; D_src_1_used = 0; D_src_0_rf = 0; D_src_1_rf = 0;
        D_dst_addr = 0; D_wb_en = 0; D_is_ld = 0; X_result_ALU = 0;
        XM_valid = 0; XM_wb_en = 0; XM_dst_addr = 0; XM_result = 0;
        MW_valid = 0; MW_wb_en = 0; MW_dst_addr = 0; MW_result = 0;
        X_flush = 0; X_hold = 0;
    endtask

    task automatic drive_d(input logic [3:0] opc, input logic [3:0] dst, input logic ld,
                           input logic [3:0] a0, input logic [7:0] rf0,
                           input logic [3:0] a1, input logic [7:0] rf1);
        D_valid = 1; D_insn_opc = opc; D_dst_addr = dst; D_wb_en = 1; D_is_ld = ld;
        D_src_0_addr = a0; D_src_0_rf = rf0; D_src_0_used = 1;
        D_src_1_addr = a1; D_src_1_rf = rf1; D_src_1_used = 1;
    endtask

    // one clock with current inputs: check stall, advance model, check registered state
    task automatic step();
        logic hz, st;
        logic [7:0] v0, v1;
        #1;
        hz = D_valid && m_valid && m_ld && m_wb &&
             ((D_src_0_used && m_dst == D_src_0_addr) || (D_src_1_used && m_dst == D_src_1_addr));
        st = !X_flush && (X_hold || hz);
        chk("d_stall", D_stall, st);
        v0 = resolve(D_src_0_addr, D_src_0_rf);
        v1 = resolve(D_src_1_addr, D_src_1_rf);
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (X_flush) m_valid = 0;
        else if (!X_hold) begin
            if (hz) m_valid = 0;
            else begin
                if (D_valid || m_valid) begin
                    m_opc = D_insn_opc; m_dst = D_dst_addr; m_wb = D_wb_en; m_ld = D_is_ld;
                    m_s0 = v0; m_s1 = v1;
                end
                m_valid = D_valid;
            end
        end
        @(posedge clk);
        #1;
        chk("dx_valid", DX_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
            chk("opc", DX_insn_opc, m_opc);
            chk("src0", src_0_data_ALU, m_s0);
            chk("src1", src_1_data_ALU, m_s1);
            chk("dst", DX_dst_addr, m_dst);
            chk("wb_en", DX_wb_en, m_wb);
            chk("is_ld", DX_is_ld, m_ld);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, DX_valid, 0);
        chk({tag, "_opc"}, DX_insn_opc, 0);
        chk({tag, "_src0"}, src_0_data_ALU, 0);
        chk({tag, "_src1"}, src_1_data_ALU, 0);
        chk({tag, "_dst"}, DX_dst_addr, 0);
        chk({tag, "_wb"}, DX_wb_en, 0);
        chk({tag, "_ld"}, DX_is_ld, 0);
        chk({tag, "_stall"}, D_stall, 0);
        chk({tag, "_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        reset = 1;
        X_hold = 1;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("rst");
        X_hold = 0;
        reset = 0;

        // plain issue, no hazard
        drive_d(ADD, 4'd3, 0, 4'd1, 8'd5, 4'd1, 8'd5);
        step();
        chk("t1_src0", src_0_data_ALU, 5);
        chk("t1_src1", src_1_data_ALU, 5);
        chk("t1_opc", DX_insn_opc, ADD);
        chk("t1_valid", DX_valid, 1);

        // ALU-result bypass
        drive_d(ADD, 4'd2, 0, 4'd1, 8'd5, 4'd1, 8'd5);
        step();
        X_result_ALU = 8'd9;
        drive_d(SUB, 4'd4, 0, 4'd2, 8'd0, 4'd1, 8'd5);
        step();
        chk("t2_src0", src_0_data_ALU, 9);
        chk("t2_src1", src_1_data_ALU, 5);

        // M beats W; W alone
        XM_valid = 1; XM_wb_en = 1; XM_dst_addr = 4'd2; XM_result = 8'd7;
        MW_valid = 1; MW_wb_en = 1; MW_dst_addr = 4'd2; MW_result = 8'd3;
        drive_d(ADD, 4'd5, 0, 4'd2, 8'd0, 4'd2, 8'd0);
        step();
        chk("t3_xm", src_0_data_ALU, 7);
        XM_valid = 0;
        step();
        chk("t3_mw", src_0_data_ALU, 3);
        MW_valid = 0;

        // load-use: one bubble, then M-stage value
        drive_d(LD, 4'd2, 1, 4'd1, 8'd5, 4'd1, 8'd5);
        step();
        drive_d(ADD, 4'd5, 0, 4'd2, 8'd0, 4'd2, 8'd0);
        #1;
        chk("t4_stall", D_stall, 1);
        step();
        chk("t4_bubble", DX_valid, 0);
        chk("t4_cnt", stall_cnt, 1);
        XM_valid = 1; XM_wb_en = 1; XM_dst_addr = 4'd2; XM_result = 8'h42;
        step();
        chk("t4_valid", DX_valid, 1);
        chk("t4_src0", src_0_data_ALU, 8'h42);
        XM_valid = 0;

        // hold freezes, flush overrides hold
        X_hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive_d(SUB, 4'(i + 7), 0, 4'd1, 8'($urandom), 4'd1, 8'($urandom));
            step();
            chk("t5_frozen_v", DX_valid, 1);
            chk("t5_frozen_s", src_0_data_ALU, 8'h42);
        end
        chk("t5_cnt", stall_cnt, 4);
        X_flush = 1;
        #1;
        chk("t5_flush_stall", D_stall, 0);
        step();
        chk("t5_flush_v", DX_valid, 0);
        X_flush = 0; X_hold = 0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            D_valid = ($urandom_range(0, 3) != 0);
            D_insn_opc = 4'($urandom);
            D_src_0_addr = 4'($urandom_range(0, 3)); D_src_1_addr = 4'($urandom_range(0, 3));
            D_src_0_used = 1'($urandom); D_src_1_used = 1'($urandom);
            D_src_0_rf = 8'($urandom); D_src_1_rf = 8'($urandom);
            D_dst_addr = 4'($urandom_range(0, 3));
            D_wb_en = ($urandom_range(0, 3) != 0); D_is_ld = ($urandom_range(0, 2) == 0);
            X_result_ALU = 8'($urandom);
            XM_valid = 1'($urandom); XM_wb_en = 1'($urandom);
            XM_dst_addr = 4'($urandom_range(0, 3)); XM_result = 8'($urandom);
            MW_valid = 1'($urandom); MW_wb_en = 1'($urandom);
            MW_dst_addr = 4'($urandom_range(0, 3)); MW_result = 8'($urandom);
            X_flush = ($urandom_range(0, 19) == 0);
            X_hold = ($urandom_range(0, 9) == 0);
            step();
        end

        // drive the counter to saturation
        idle();
        X_hold = 1;
        while (m_cnt < 16'hFFFD) step();
        chk("sat_pre", stall_cnt, 16'hFFFD);
        step();
        step();
        chk("sat_max", stall_cnt, 16'hFFFF);
        step();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        X_hold = 0;

        // async reset in the middle of a load-use stall
        drive_d(LD, 4'd3, 1, 4'd1, 8'd5, 4'd1, 8'd5);
        step();
        drive_d(ADD, 4'd6, 0, 4'd3, 8'd0, 4'd1, 8'd5);
        #1;
        chk("t6_lu_stall", D_stall, 1);
        #2;
        reset = 1;
        #1;
        chk_all_zero("async");
        #1;
        reset = 0;
        model_reset();
        step();
        chk("t6_post_valid", DX_valid, 1);
        chk("t6_post_src0", src_0_data_ALU, 0);
        chk("t6_post_opc", DX_insn_opc, ADD);

        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end

endmodule
